instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Front-end fetch stage, directly upstream of instruction decode. Holds the PC and drives the synchronous-read I-mem address. Predicts the next PC with a direct-mapped BTB plus a gshare PHT/GHR. Hands decode, aligned with the I-mem output, the fetched PC, predicted next PC, GHR index, PHT state and redirect flag. Honours decode's freeze and the ROB flush/redirect.

Parameters:
WIDTH, 31, MSB of PC/data (32-bit)
INDEX, 7, MSB of GHR/PHT index (256-entry PHT, 8-bit GHR)
BTB_IDX, 3, MSB of BTB index (16 entries, index PC[5:2])
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk  in  1  clock
globalReset_n  in  1  synchronous, active-low reset
freeze  in  1  decode stall; hold all state and outputs
flush  in  1  ROB control-flow flush (controlFlow[0])
flushPC  in  WIDTH+1  correct PC after flush
restoreGHR  in  INDEX+1  non-speculative GHR restored on flush
updValid  in  1  resolved control-flow instruction
updIsCond  in  1  resolved instruction is a conditional branch
updTaken  in  1  actual outcome
updIndex  in  INDEX+1  PHT index carried with the instruction
updPC  in  WIDTH+1  PC of resolved instruction
updTarget  in  WIDTH+1  actual target
imemAddr  out  WIDTH+1  I-mem read address (= PC register, combinational)
instrPC  out  WIDTH+1  PC of instruction now leaving I-mem
predictedPCF  out  WIDTH+1  predicted successor of instrPC
GHRIndex  out  INDEX+1  gshare index used for instrPC
PHTState  out  2  PHT counter read for instrPC
redirect  out  1  prediction differs from instrPC+4
fetchValid  out  1  outputs carry a real instruction (0 = bubble)

Behaviour:
- Reset (globalReset_n=0 at clk edge): PC<=RESET_PC, GHR<=0, all PHT counters <=2'b01, all BTB valid <=0. instrPC, predictedPCF, GHRIndex, PHTState, redirect, fetchValid <=0.
- Lookup (combinational on PC):
  - idx = PC[INDEX+2:2] ^ GHR.
  - BTB hit = valid & tag==PC[WIDTH:BTB_IDX+3].
  - takenPred = hit & (!isCond | PHT[idx][1]).
  - nextPC = takenPred ? BTB target : PC+4. Wraps modulo 2^32.
- Priority per edge is reset > flush > freeze > advance.
- Flush:
  - PC<=flushPC, GHR<=restoreGHR.
  - Output regs cleared, fetchValid<=0: one bubble.
  - fetchValid returns to 1 on the next non-frozen edge.
- Freeze (no flush):
  - PC, GHR and every output register hold.
  - imemAddr stays stable, so I-mem re-reads the same address.
- Advance: PC<=nextPC. Outputs register in the same edge as I-mem latches its word, so latency is 1 cycle from imemAddr to instrPC/instruction:
  - instrPC<=PC
  - predictedPCF<=nextPC
  - GHRIndex<=idx
  - PHTState<=PHT[idx]
  - redirect<=takenPred
  - fetchValid<=1
- Speculative GHR: on advance with a BTB hit on a conditional branch, GHR<={GHR[INDEX-1:0],takenPred}. Otherwise GHR holds.
- Training happens every edge with updValid=1 (and reset high), independent of freeze and flush:
  - If updIsCond, PHT[updIndex] saturates up on updTaken and down otherwise; it stays at 11 or 00 at the limits.
  - If updTaken, the BTB entry at updPC[BTB_IDX+2:2] is written {valid=1, tag, updTarget, updIsCond}.
  - A not-taken resolution never allocates in the BTB.
- Same-cycle read/write to the same PHT/BTB entry: the lookup sees the old value (write-after-read).
- Flush with a simultaneous update: both take effect. The GHR takes restoreGHR; the update never touches the GHR.

Decomposition:
- Package fetch_pkg:
  - btb_entry_t struct {valid, tag, target, isCond}
  - RESET_PC
  - PHT encodings: SNT=00, WNT=01, WT=10, ST=11
- One sub-module, gshare_predictor: PHT array, GHR register, index hash, saturating update, speculative shift and restore.
- BTB and PC logic stay in instr_fetch.

Test Plan:
- Reset, then 4 free-running cycles with empty BTB -> instrPC 0,4,8,C; predictedPCF = instrPC+4; redirect=0; fetchValid=1 from the first post-reset edge.
- Train a taken JAL (updValid=1, updIsCond=0, updPC=0x10, updTarget=0x40), then refetch 0x10 -> predictedPCF=0x40, redirect=1, next instrPC=0x40, GHR unchanged.
- Conditional branch at 0x20 (target 0x80): three taken updates at its index -> counter 01->10->11->11 (saturates); fetch of 0x20 gives PHTState=11, redirect=1, and GHR shifts in 1.
- Freeze held 3 cycles mid-stream -> all outputs and imemAddr constant; release resumes at the held PC+4 with no skipped or duplicated PC.
- Flush with flushPC=0x100, restoreGHR=8'hA5, while frozen -> next edge fetchValid=0, GHR=0xA5, imemAddr=0x100; following edge instrPC=0x100, fetchValid=1.
- Update and lookup of the same PHT index in one cycle (counter 01, taken update) -> PHTState output 01; counter reads 10 next fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: BTB entry layout,
// 2-bit PHT counter encodings and the counter update rule.
package fetch_pkg;

  localparam int PC_MSB  = 31;
  localparam int IDX_MSB = 7;
  localparam int BTB_MSB = 3;
  localparam int TAG_W   = PC_MSB - BTB_MSB - 2;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [PC_MSB:0]   target;
    logic              is_cond;
  } btb_entry_t;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] pht_next(input logic [1:0] s, input logic taken);
    if (taken) return (s == ST) ? ST : s + 2'd1;
    else       return (s == SNT) ? SNT : s - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PHT of 2-bit counters indexed by PC ^ GHR,
// with a speculative history shift and a non-speculative restore on flush.
module gshare_predictor
  import fetch_pkg::*;
#(
  parameter int INDEX = IDX_MSB
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [INDEX:0]   i_pc_bits,
  input  logic             i_spec_shift,
  input  logic             i_spec_bit,
  input  logic             i_restore,
  input  logic [INDEX:0]   i_restore_ghr,
  input  logic             i_upd_valid,
  input  logic             i_upd_taken,
  input  logic [INDEX:0]   i_upd_index,
  output logic [INDEX:0]   o_idx,
  output logic [1:0]       o_state
);

  localparam int PHT_N = 2 ** (INDEX + 1);

  logic [INDEX:0]   r_ghr;
  logic [1:0]       r_pht [PHT_N];
  logic [PHT_N-1:0] w_pht_we;
  logic [INDEX:0]   w_idx;

  assign w_idx   = i_pc_bits ^ r_ghr;
  assign o_idx   = w_idx;
  assign o_state = r_pht[w_idx];

  for (genvar gi = 0; gi < PHT_N; gi++) begin : g_pht_we
    assign w_pht_we[gi] = i_upd_valid && (i_upd_index == (INDEX + 1)'(gi));
  end

  // Restore outranks the speculative shift; a flush cycle never advances.
  always_ff @(posedge clk) begin
    if (!i_rst_n)          r_ghr <= '0;
    else if (i_restore)    r_ghr <= i_restore_ghr;
    else if (i_spec_shift) r_ghr <= {r_ghr[INDEX-1:0], i_spec_bit};
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= WNT;
    end else begin
      for (int i = 0; i < PHT_N; i++)
        if (w_pht_we[i]) r_pht[i] <= pht_next(r_pht[i], i_upd_taken);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, direct-mapped BTB and gshare lookup, with outputs
// registered alongside the synchronous I-mem read so decode sees them aligned.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          WIDTH    = PC_MSB,
  parameter int          INDEX    = IDX_MSB,
  parameter int          BTB_IDX  = BTB_MSB,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic             clk,
  input  logic             globalReset_n,
  input  logic             freeze,
  input  logic             flush,
  input  logic [WIDTH:0]   flushPC,
  input  logic [INDEX:0]   restoreGHR,
  input  logic             updValid,
  input  logic             updIsCond,
  input  logic             updTaken,
  input  logic [INDEX:0]   updIndex,
  input  logic [WIDTH:0]   updPC,
  input  logic [WIDTH:0]   updTarget,
  output logic [WIDTH:0]   imemAddr,
  output logic [WIDTH:0]   instrPC,
  output logic [WIDTH:0]   predictedPCF,
  output logic [INDEX:0]   GHRIndex,
  output logic [1:0]       PHTState,
  output logic             redirect,
  output logic             fetchValid
);

  localparam int BTB_N = 2 ** (BTB_IDX + 1);

  logic [WIDTH:0]   r_pc;
  logic [WIDTH:0]   r_instr_pc;
  logic [WIDTH:0]   r_pred_pc;
  logic [INDEX:0]   r_ghr_index;
  logic [1:0]       r_pht_state;
  logic             r_redirect;
  logic             r_fetch_valid;
  btb_entry_t       r_btb [BTB_N];

  logic [BTB_N-1:0] w_btb_we;
  btb_entry_t       w_btb_wr;
  btb_entry_t       w_btb_rd;
  logic             w_hit;
  logic             w_taken;
  logic             w_advance;
  logic [WIDTH:0]   w_next_pc;
  logic [INDEX:0]   w_idx;
  logic [1:0]       w_pht_state;
  logic             w_unused;

  assign w_unused = ^updPC[1:0];

  // BTB lookup and next-PC prediction, all combinational on the PC register.
  assign w_btb_rd  = r_btb[r_pc[BTB_IDX+2:2]];
  assign w_hit     = w_btb_rd.valid && (w_btb_rd.tag == r_pc[WIDTH:BTB_IDX+3]);
  assign w_taken   = w_hit && (!w_btb_rd.is_cond || w_pht_state[1]);
  assign w_next_pc = w_taken ? w_btb_rd.target : r_pc + (WIDTH + 1)'(4);
  assign w_advance = !flush && !freeze;

  gshare_predictor #(.INDEX(INDEX)) u_gshare (
    .clk           (clk),
    .i_rst_n       (globalReset_n),
    .i_pc_bits     (r_pc[INDEX+2:2]),
    .i_spec_shift  (w_advance && w_hit && w_btb_rd.is_cond),
    .i_spec_bit    (w_taken),
    .i_restore     (flush),
    .i_restore_ghr (restoreGHR),
    .i_upd_valid   (updValid && updIsCond),
    .i_upd_taken   (updTaken),
    .i_upd_index   (updIndex),
    .o_idx         (w_idx),
    .o_state       (w_pht_state)
  );

  assign w_btb_wr = '{valid:   1'b1,
                      tag:     updPC[WIDTH:BTB_IDX+3],
                      target:  updTarget,
                      is_cond: updIsCond};

  for (genvar gi = 0; gi < BTB_N; gi++) begin : g_btb_we
    assign w_btb_we[gi] = updValid && updTaken &&
                          (updPC[BTB_IDX+2:2] == (BTB_IDX + 1)'(gi));
  end

  // Only taken resolutions allocate, so not-taken branches never pollute the BTB.
  always_ff @(posedge clk) begin
    if (!globalReset_n) begin
      for (int i = 0; i < BTB_N; i++) r_btb[i] <= '0;
    end else begin
      for (int i = 0; i < BTB_N; i++)
        if (w_btb_we[i]) r_btb[i] <= w_btb_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (!globalReset_n) begin
      r_pc          <= RESET_PC[WIDTH:0];
      r_instr_pc    <= '0;
      r_pred_pc     <= '0;
      r_ghr_index   <= '0;
      r_pht_state   <= '0;
      r_redirect    <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else if (flush) begin
      r_pc          <= flushPC;
      r_instr_pc    <= '0;
      r_pred_pc     <= '0;
      r_ghr_index   <= '0;
      r_pht_state   <= '0;
      r_redirect    <= 1'b0;
      r_fetch_valid <= 1'b0;
    end else if (!freeze) begin
      r_pc          <= w_next_pc;
      r_instr_pc    <= r_pc;
      r_pred_pc     <= w_next_pc;
      r_ghr_index   <= w_idx;
      r_pht_state   <= w_pht_state;
      r_redirect    <= w_taken;
      r_fetch_valid <= 1'b1;
    end
  end

  assign imemAddr     = r_pc;
  assign instrPC      = r_instr_pc;
  assign predictedPCF = r_pred_pc;
  assign GHRIndex     = r_ghr_index;
  assign PHTState     = r_pht_state;
  assign redirect     = r_redirect;
  assign fetchValid   = r_fetch_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios then random traffic,
// each edge's expected outputs come from an abstract predictor model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        globalReset_n;
  logic        freeze, flush;
  logic [31:0] flushPC;
  logic [7:0]  restoreGHR;
  logic        updValid, updIsCond, updTaken;
  logic [7:0]  updIndex;
  logic [31:0] updPC, updTarget;
  logic [31:0] imemAddr, instrPC, predictedPCF;
  logic [7:0]  GHRIndex;
  logic [1:0]  PHTState;
  logic        redirect, fetchValid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .globalReset_n(globalReset_n), .freeze(freeze), .flush(flush),
    .flushPC(flushPC), .restoreGHR(restoreGHR), .updValid(updValid),
    .updIsCond(updIsCond), .updTaken(updTaken), .updIndex(updIndex),
    .updPC(updPC), .updTarget(updTarget), .imemAddr(imemAddr),
    .instrPC(instrPC), .predictedPCF(predictedPCF), .GHRIndex(GHRIndex),
    .PHTState(PHTState), .redirect(redirect), .fetchValid(fetchValid)
  );

  typedef struct {
    logic [31:0] ipc;
    logic [31:0] ppc;
    logic [7:0]  gidx;
    logic [1:0]  pht;
    logic        redir;
    logic        fv;
    logic [31:0] imem;
  } exp_t;

  exp_t q[$];

  // Reference model state: PC, history, counters as integers, BTB as arrays.
  logic [31:0] m_pc;
  logic [7:0]  m_ghr;
  int          m_pht [256];
  bit          m_bv [16];
  logic [31:0] m_btag [16];
  logic [31:0] m_btgt [16];
  bit          m_bc [16];
  exp_t        m_out;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_step();
    int idx, e, st;
    bit hit, taken;
    logic [31:0] nxt;
    if (!globalReset_n) begin
      m_pc = 32'h0; m_ghr = 8'h0;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      for (int i = 0; i < 16; i++) m_bv[i] = 0;
      m_out = '{32'h0, 32'h0, 8'h0, 2'b00, 1'b0, 1'b0, 32'h0};
    end else begin
      idx   = ((m_pc >> 2) & 255) ^ m_ghr;
      e     = (m_pc >> 2) & 15;
      hit   = m_bv[e] && (m_btag[e] == (m_pc >> 6));
      taken = hit && (!m_bc[e] || m_pht[idx] >= 2);
      nxt   = taken ? m_btgt[e] : m_pc + 32'd4;
      if (flush) begin
        m_pc = flushPC; m_ghr = restoreGHR;
        m_out = '{32'h0, 32'h0, 8'h0, 2'b00, 1'b0, 1'b0, 32'h0};
      end else if (!freeze) begin
        m_out.ipc = m_pc; m_out.ppc = nxt; m_out.gidx = 8'(idx);
        m_out.pht = 2'(m_pht[idx]); m_out.redir = taken; m_out.fv = 1'b1;
        if (hit && m_bc[e]) m_ghr = 8'((m_ghr << 1) | taken);
        m_pc = nxt;
      end
      if (updValid) begin
        if (updIsCond) begin
          st = m_pht[updIndex];
          m_pht[updIndex] = updTaken ? ((st == 3) ? 3 : st + 1) : ((st == 0) ? 0 : st - 1);
        end
        if (updTaken) begin
          e = (updPC >> 2) & 15;
          m_bv[e] = 1; m_btag[e] = updPC >> 6; m_btgt[e] = updTarget; m_bc[e] = updIsCond;
        end
      end
    end
    m_out.imem = m_pc;
    q.push_back(m_out);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    freeze = 0; flush = 0; flushPC = 0; restoreGHR = 0;
    updValid = 0; updIsCond = 0; updTaken = 0; updIndex = 0; updPC = 0; updTarget = 0;
  endtask

  task automatic do_flush(input logic [31:0] pc, input logic [7:0] g, input bit frz);
    idle(); freeze = frz; flush = 1; flushPC = pc; restoreGHR = g;
    step();
    idle();
  endtask

  // Monitor: one expected record per clock edge, popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got no expected entry required one (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        cmp("sb_fetchValid", 32'(fetchValid), 32'(e.fv));
        cmp("sb_imemAddr", imemAddr, e.imem);
        cmp("sb_instrPC", instrPC, e.ipc);
        cmp("sb_predictedPCF", predictedPCF, e.ppc);
        cmp("sb_GHRIndex", 32'(GHRIndex), 32'(e.gidx));
        cmp("sb_PHTState", 32'(PHTState), 32'(e.pht));
        cmp("sb_redirect", 32'(redirect), 32'(e.redir));
      end
    end
  end

  initial begin
    idle();
    globalReset_n = 0;
    step(); step();
    cmp("reset_fetchValid", 32'(fetchValid), 0);
    cmp("reset_imemAddr", imemAddr, 32'h0);
    globalReset_n = 1;

    // Empty BTB: sequential fetch 0,4,8,C.
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("seq_instrPC", instrPC, 32'(4 * i));
      cmp("seq_predictedPCF", predictedPCF, 32'(4 * i + 4));
      cmp("seq_redirect", 32'(redirect), 0);
      cmp("seq_fetchValid", 32'(fetchValid), 1);
    end

    // Train a JAL at 0x10 -> 0x40, refetch it.
    updValid = 1; updIsCond = 0; updTaken = 1; updPC = 32'h10; updTarget = 32'h40;
    step();
    cmp("jal_war_redirect", 32'(redirect), 0);
    do_flush(32'h10, 8'h00, 0);
    step();
    cmp("jal_instrPC", instrPC, 32'h10);
    cmp("jal_predictedPCF", predictedPCF, 32'h40);
    cmp("jal_redirect", 32'(redirect), 1);
    step();
    cmp("jal_target_instrPC", instrPC, 32'h40);
    cmp("jal_ghr_unchanged_idx", 32'(GHRIndex), 32'h10);

    // Conditional at 0x20 -> 0x80: three taken updates while frozen.
    idle(); freeze = 1;
    updValid = 1; updIsCond = 1; updTaken = 1; updIndex = 8'h08; updPC = 32'h20; updTarget = 32'h80;
    step(); step(); step();
    do_flush(32'h20, 8'h00, 0);
    step();
    cmp("cond_instrPC", instrPC, 32'h20);
    cmp("cond_PHTState", 32'(PHTState), 32'h3);
    cmp("cond_redirect", 32'(redirect), 1);
    cmp("cond_predictedPCF", predictedPCF, 32'h80);
    step();
    cmp("cond_ghr_shift_idx", 32'(GHRIndex), 32'h21);

    // Freeze for three cycles mid-stream.
    step();
    cmp("pre_freeze_instrPC", instrPC, 32'h84);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("freeze_instrPC", instrPC, 32'h84);
      cmp("freeze_imemAddr", imemAddr, 32'h88);
      cmp("freeze_predictedPCF", predictedPCF, 32'h88);
    end
    freeze = 0;
    step();
    cmp("unfreeze_instrPC", instrPC, 32'h88);
    step();
    cmp("unfreeze_next_instrPC", instrPC, 32'h8C);

    // Flush while frozen.
    do_flush(32'h100, 8'hA5, 1);
    cmp("flush_fetchValid", 32'(fetchValid), 0);
    cmp("flush_imemAddr", imemAddr, 32'h100);
    step();
    cmp("flush_instrPC", instrPC, 32'h100);
    cmp("flush_fetchValid_back", 32'(fetchValid), 1);
    cmp("flush_restored_ghr_idx", 32'(GHRIndex), 32'hE5);

    // Same-cycle PHT update and lookup of index 0xE4.
    updValid = 1; updIsCond = 1; updTaken = 1; updIndex = 8'hE4; updPC = 32'h300; updTarget = 32'h200;
    step();
    cmp("war_GHRIndex", 32'(GHRIndex), 32'hE4);
    cmp("war_PHTState_old", 32'(PHTState), 32'h1);
    do_flush(32'h104, 8'hA5, 0);
    step();
    cmp("war_PHTState_new", 32'(PHTState), 32'h2);

    // PC+4 wraps at the top of the address space.
    do_flush(32'hFFFF_FFFC, 8'h00, 0);
    step();
    cmp("wrap_instrPC", instrPC, 32'hFFFF_FFFC);
    cmp("wrap_predictedPCF", predictedPCF, 32'h0);
    cmp("wrap_imemAddr", imemAddr, 32'h0);

    // Random traffic over a small address window so BTB hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      globalReset_n = ($urandom_range(0, 299) != 0);
      freeze     = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      flushPC    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      restoreGHR = 8'($urandom);
      updValid   = ($urandom_range(0, 2) == 0);
      updIsCond  = $urandom_range(0, 1);
      updTaken   = $urandom_range(0, 1);
      updIndex   = ($urandom_range(0, 1) == 0) ? 8'(imemAddr[9:2] ^ 8'($urandom_range(0, 3))) : 8'($urandom);
      updPC      = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      updTarget  = ($urandom_range(0, 15) == 0) ? {$urandom} & 32'hFFFF_FFFC
                                                : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step();
    end

    idle();
    step(); step();
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
